// File: rtl/fetch_align_buf_if.sv
// Fetch-side and decode-side handshake bundle for the instruction alignment buffer.
// The slave modport is the buffer; the master modport is the surrounding fetch/decode logic.
interface fetch_align_buf_if #(
    parameter int XLEN = 64
);
    logic            i_fetch_valid;
    logic            o_fetch_ready;
    logic [31:0]     i_fetch_data;
    logic            i_redirect;
    logic [XLEN-1:0] i_redirect_pc;
    logic            o_instr_valid;
    logic            i_instr_ready;
    logic [31:0]     o_instr;
    logic            o_is_compressed;
    logic [XLEN-1:0] o_instr_pc;

    modport slave (
        input  i_fetch_valid, i_fetch_data, i_redirect, i_redirect_pc, i_instr_ready,
        output o_fetch_ready, o_instr_valid, o_instr, o_is_compressed, o_instr_pc
    );

    modport master (
        output i_fetch_valid, i_fetch_data, i_redirect, i_redirect_pc, i_instr_ready,
        input  o_fetch_ready, o_instr_valid, o_instr, o_is_compressed, o_instr_pc
    );
endinterface

// File: rtl/fetch_align_buf.sv
// Three-parcel alignment buffer: turns word-aligned fetch words into whole 16/32-bit
// instructions for decode, including 32-bit instructions straddling two fetch words.
module fetch_align_buf #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    fetch_align_buf_if.slave     io
);
    logic [15:0]     parcel_r    [3];
    logic [15:0]     parcel_nx_s [3];
    logic [15:0]     shift_s     [3];
    logic [1:0]      cnt_r, cnt_nx_s;
    logic [XLEN-1:0] head_pc_r, head_pc_nx_s, pc_inc_s;
    logic            skip_lo_r, skip_lo_nx_s;
    logic            is_comp_s, valid_s, fetch_ready_s, consume_s, accept_s;
    logic [1:0]      n_cons_s, n_app_s, rem_s;
    logic [15:0]     app0_s;
    logic [31:0]     instr_s;

    // Head decode and handshake qualification, all from registered state.
    always_comb begin
        is_comp_s     = (cnt_r != 2'd0) && (parcel_r[0][1:0] != 2'b11);
        valid_s       = is_comp_s || (cnt_r >= 2'd2);
        if (cnt_r == 2'd0) begin
            instr_s = 32'd0;
        end else if (is_comp_s) begin
            instr_s = {16'd0, parcel_r[0]};
        end else begin
            instr_s = {parcel_r[1], parcel_r[0]};
        end
        fetch_ready_s = (cnt_r <= 2'd1) && !io.i_redirect;
        consume_s     = valid_s && io.i_instr_ready;
        accept_s      = io.i_fetch_valid && fetch_ready_s;
    end

    // Next buffer state: drop consumed parcels, then append the new word behind what remains.
    always_comb begin
        if (!consume_s) begin
            n_cons_s = 2'd0;
        end else if (is_comp_s) begin
            n_cons_s = 2'd1;
        end else begin
            n_cons_s = 2'd2;
        end
        rem_s = cnt_r - n_cons_s;

        case (n_cons_s)
            2'd1: begin
                shift_s[0] = parcel_r[1];
                shift_s[1] = parcel_r[2];
                shift_s[2] = parcel_r[2];
            end
            2'd2: begin
                shift_s[0] = parcel_r[2];
                shift_s[1] = parcel_r[2];
                shift_s[2] = parcel_r[2];
            end
            default: begin
                shift_s[0] = parcel_r[0];
                shift_s[1] = parcel_r[1];
                shift_s[2] = parcel_r[2];
            end
        endcase

        // After a redirect to an odd halfword the low half of the first word is not ours.
        app0_s = skip_lo_r ? io.i_fetch_data[31:16] : io.i_fetch_data[15:0];
        if (!accept_s) begin
            n_app_s = 2'd0;
        end else if (skip_lo_r) begin
            n_app_s = 2'd1;
        end else begin
            n_app_s = 2'd2;
        end

        for (int i = 0; i < 3; i++) begin
            if (accept_s && (2'(i) == rem_s)) begin
                parcel_nx_s[i] = app0_s;
            end else if (accept_s && !skip_lo_r && (3'(i) == ({1'b0, rem_s} + 3'd1))) begin
                parcel_nx_s[i] = io.i_fetch_data[31:16];
            end else begin
                parcel_nx_s[i] = shift_s[i];
            end
        end

        pc_inc_s = '0;
        if (n_cons_s == 2'd1) begin
            pc_inc_s[2:0] = 3'd2;
        end else if (n_cons_s == 2'd2) begin
            pc_inc_s[2:0] = 3'd4;
        end else begin
            pc_inc_s[2:0] = 3'd0;
        end

        if (io.i_redirect) begin
            cnt_nx_s     = 2'd0;
            head_pc_nx_s = io.i_redirect_pc;
            skip_lo_nx_s = io.i_redirect_pc[1];
        end else begin
            cnt_nx_s     = rem_s + n_app_s;
            head_pc_nx_s = head_pc_r + pc_inc_s;
            skip_lo_nx_s = accept_s ? 1'b0 : skip_lo_r;
        end
    end

    // Buffer state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r     <= 2'd0;
            head_pc_r <= RESET_PC;
            skip_lo_r <= RESET_PC[1];
            for (int i = 0; i < 3; i++) begin
                parcel_r[i] <= 16'd0;
            end
        end else begin
            cnt_r     <= cnt_nx_s;
            head_pc_r <= head_pc_nx_s;
            skip_lo_r <= skip_lo_nx_s;
            for (int i = 0; i < 3; i++) begin
                parcel_r[i] <= parcel_nx_s[i];
            end
        end
    end

    assign io.o_fetch_ready   = fetch_ready_s;
    assign io.o_instr_valid   = valid_s;
    assign io.o_instr         = instr_s;
    assign io.o_is_compressed = is_comp_s;
    assign io.o_instr_pc      = head_pc_r;
endmodule

// File: doc/fetch_align_buf.md
Name: fetch_align_buf

Overview:
- Instruction-alignment buffer between the instruction-fetch port and the decode stage (decompressor, imm_gen, control decode).
- Accepts in-order, word-aligned 32-bit fetch words and holds up to three 16-bit parcels.
- Issues one complete instruction per handshake: either a 16-bit compressed parcel (bits[1:0] != 2'b11) or a 32-bit instruction, which may straddle two fetch words.
- Handles halfword-aligned branch/jump redirects.

Parameters:
- XLEN, 64, width of PC values.
- RESET_PC, 64'h0000_0000_8000_0000, PC of the first parcel after reset; must be halfword aligned.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_fetch_valid  input  1  fetch word present.
- o_fetch_ready  output  1  buffer can take a fetch word this cycle.
- i_fetch_data  input  32  fetch word; the low halfword is at the lower address.
- i_redirect  input  1  flush and restart at i_redirect_pc.
- i_redirect_pc  input  XLEN  new PC; halfword aligned.
- o_instr_valid  output  1  a complete instruction is at the head.
- i_instr_ready  input  1  decode accepts the head instruction.
- o_instr  output  32  instruction; a compressed instruction is zero-extended to {16'b0, parcel}.
- o_is_compressed  output  1  head parcel bits[1:0] != 2'b11.
- o_instr_pc  output  XLEN  PC of the head instruction.

Behaviour:
- Storage:
  - Parcel array buf[0..2] of 16 bits each; cnt in 0..3.
  - head_pc is the PC of buf[0].
  - skip_lo flag.
- Reset (asynchronous, i_rst_n=0):
  - cnt=0, head_pc=RESET_PC, skip_lo=RESET_PC[1].
  - Outputs: o_instr_valid=0, o_instr=0, o_is_compressed=0, o_instr_pc=RESET_PC, o_fetch_ready=1.
  - Reset asserted mid-operation discards all parcels immediately.
- o_fetch_ready = (cnt <= 1) && !i_redirect. Combinational from registered state.
- Head decode (all combinational, zero latency from buffer state to outputs):
  - o_is_compressed = (cnt>=1) && (buf[0][1:0] != 2'b11).
  - o_instr_valid = (cnt>=1 && o_is_compressed) || (cnt>=2).
  - o_instr = o_is_compressed ? {16'b0, buf[0]} : {buf[1], buf[0]}.
  - When cnt=0, o_instr and o_is_compressed are 0.
  - o_instr_pc = head_pc.
- Consume (o_instr_valid && i_instr_ready):
  - Remove 1 parcel if compressed, else 2.
  - Shift the remaining parcels down to buf[0].
  - head_pc += 2 or 4, wrapping modulo 2^XLEN.
- Accept (i_fetch_valid && o_fetch_ready):
  - If skip_lo=1: append only i_fetch_data[31:16] (1 parcel) and clear skip_lo.
  - Otherwise append [15:0] then [31:16] (2 parcels).
  - Appended parcels are placed after the parcels that remain post-consume.
- Consume and accept in the same cycle:
  - Consume is applied first, then the append, in one update.
  - cnt_next = cnt - consumed + appended; this never exceeds 3.
- Redirect (i_redirect=1) has the highest priority over consume and accept:
  - Next cycle: cnt=0, head_pc=i_redirect_pc, skip_lo=i_redirect_pc[1].
  - No handshake occurs that cycle: o_fetch_ready is forced 0.
  - A concurrent i_fetch_valid word is dropped and is not counted as accepted.
  - A concurrent decode handshake is ignored; the decode stage owns squashing.
  - The fetch unit must supply words starting at {i_redirect_pc[XLEN-1:2], 2'b00}.
- A 32-bit instruction split across words (cnt=1 with a non-compressed head):
  - o_instr_valid stays 0 until the next word is appended.
  - The instruction is presented the cycle after the append.
- Stalls: o_instr, o_instr_pc and o_instr_valid hold stable while i_instr_ready=0. There is no bubble insertion.
- There is no illegal-instruction detection. 16'h0000 is passed through as compressed.

Test Plan:
- Reset, then 3 fetch words of aligned 32-bit instructions 0x00500093, 0x00A00113, 0x002081B3 with i_instr_ready=1 → three instructions issued, pc 0x80000000/…04/…08, o_is_compressed=0.
- Word 0x4505_4581 (c.li a1,0 then c.li a0,1) → two compressed issues, o_instr 0x00004581 at pc 0x80000000, then 0x00004505 at 0x80000002; the next word is accepted only when cnt<=1.
- Straddle: words 0x0093_4581 and 0x0000_0050 → c.li at 0x80000000, then 0x00500093 at 0x80000002 valid only after the second word is accepted.
- Redirect to 0x80001002 with a word present in the same cycle → that word dropped, o_instr_valid=0 next cycle; next word 0x4505_0001 yields only 0x00004505 at pc 0x80001002.
- Backpressure: i_instr_ready=0 for 5 cycles with cnt=3 → o_fetch_ready=0, outputs stable, no parcel loss after release.
- Assert i_rst_n=0 asynchronously mid-stream with cnt=2 → o_instr_valid falls before the next clock edge; after release o_instr_pc=RESET_PC.
